// File: rtl/ram_sweep.sv
// ram_sweep: parametrised scratch RAM with a registered read port, per-word
// valid bitmap, occupancy counter and a hardware clear sweep.
//
// Optional feature: define RAM_SWEEP_FWD_EN to forward same-cycle write data
// to a read of the same address; the default build returns the pre-write word.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   we, wa, wd    write port
//   re, ra        read request and address
//   rd, rvalid    registered read data and its one-cycle strobe
//   rhit          addressed word was written since the last clear/reset
//   clr           start clear sweep (level sampled each clock)
//   busy          clear sweep in progress
//   used          number of valid words, 0..DEPTH
module ram_sweep #(
    parameter int unsigned   DW      = 4,
    parameter int unsigned   AW      = 4,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd,
    output logic          rvalid,
    output logic          rhit,
    input  logic          clr,
    output logic          busy,
    output logic [AW:0]   used
);

    localparam int unsigned DEPTH = 2 ** AW;

`ifdef RAM_SWEEP_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]    state, state_nx;
    logic [AW-1:0] ptr, ptr_nx;
    logic [DW-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld;

    logic idle_c, wr_c, rdq_c, clr_go_c, fwd_c;

    // Port qualification: nothing is accepted while sweeping or when clr wins.
    always_comb begin
        idle_c   = (state == S_IDLE);
        clr_go_c = idle_c && clr;
        wr_c     = idle_c && we && !clr;
        rdq_c    = idle_c && re && !clr;
        fwd_c    = FWD && wr_c && (wa == ra);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            busy  <= (state_nx == S_CLEAR);
        end
    end

    // Next-state logic; the sweep leaves CLEAR on the edge that writes the last word.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            S_IDLE: begin
                if (clr) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                ptr_nx = ptr + AW'(1);
                if (ptr == AW'(DEPTH - 1)) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[ptr] <= CLR_VAL;
        end else if (wr_c) begin
            mem[wa] <= wd;
        end
    end

    // Valid bitmap and occupancy; each word counts once so used saturates at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= '0;
            used <= '0;
        end else if (clr_go_c) begin
            vld  <= '0;
            used <= '0;
        end else if (wr_c && !vld[wa]) begin
            vld[wa] <= 1'b1;
            used    <= used + (AW + 1)'(1);
        end
    end

    // Registered read; invalid words read as zero, outputs hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd     <= '0;
            rhit   <= 1'b0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rdq_c;
            if (rdq_c) begin
                if (fwd_c) begin
                    rd   <= wd;
                    rhit <= 1'b1;
                end else begin
                    rd   <= vld[ra] ? mem[ra] : '0;
                    rhit <= vld[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_sweep.sv
// tb_ram_sweep: directed self-checking bench for ram_sweep (DW=4, AW=4).
// Honours RAM_SWEEP_FWD_EN for the same-cycle read/write expectations.
module tb_ram_sweep;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [3:0] wa;
    logic [3:0] wd;
    logic       re;
    logic [3:0] ra;
    logic [3:0] rd;
    logic       rvalid;
    logic       rhit;
    logic       clr;
    logic       busy;
    logic [4:0] used;

    int n_vec = 0;
    int n_err = 0;

    ram_sweep #(.DW(4), .AW(4), .CLR_VAL(4'h0)) dut (
        .clk(clk), .rst(rst),
        .we(we), .wa(wa), .wd(wd),
        .re(re), .ra(ra),
        .rd(rd), .rvalid(rvalid), .rhit(rhit),
        .clr(clr), .busy(busy), .used(used)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string name, input logic ev, input logic eh, input logic [3:0] ed);
        n_vec++;
        if (rvalid !== ev || rhit !== eh || rd !== ed) begin
            n_err++;
            $display("FAIL %s: rvalid=%b rhit=%b rd=%h, required rvalid=%b rhit=%b rd=%h",
                     name, rvalid, rhit, rd, ev, eh, ed);
        end
    endtask

    task automatic chk_used(input string name, input logic [4:0] eu);
        n_vec++;
        if (used !== eu) begin
            n_err++;
            $display("FAIL %s: used=%0d, required %0d", name, used, eu);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 0; wa = 0; wd = 0; re = 0; ra = 0; clr = 0;
        #12;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: busy=%b, required 0", busy); end
        chk_rd("reset_out", 1'b0, 1'b0, 4'h0);
        chk_used("reset_used", 5'd0);
        cyc();
        rst = 1'b0;
        re = 1; ra = 4'd5;
        cyc();
        re = 0;
        chk_rd("read5_after_reset", 1'b1, 1'b0, 4'h0);
        chk_used("used_after_reset", 5'd0);
        cyc();
        chk_rd("rvalid_falls", 1'b0, 1'b0, 4'h0);
    endtask

    task automatic test_write_read();
        we = 1; wa = 4'd3; wd = 4'hA;
        cyc();
        we = 0;
        chk_used("used_first_write", 5'd1);
        re = 1; ra = 4'd3;
        cyc();
        re = 0;
        chk_rd("read3", 1'b1, 1'b1, 4'hA);
        we = 1; wa = 4'd3; wd = 4'h6;
        cyc();
        we = 0;
        chk_used("used_rewrite", 5'd1);
        chk_rd("hold_after_read", 1'b0, 1'b1, 4'hA);
        re = 1; ra = 4'd3;
        cyc();
        re = 0;
        chk_rd("read3_rewritten", 1'b1, 1'b1, 4'h6);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            we = 1; wa = 4'(i); wd = 4'(i);
            cyc();
        end
        we = 0;
        chk_used("used_full", 5'd16);
        for (int i = 0; i < 16; i++) begin
            re = 1; ra = 4'(i);
            cyc();
            chk_rd($sformatf("b2b_read%0d", i), 1'b1, 1'b1, 4'(i));
        end
        re = 0;
        cyc();
        chk_rd("b2b_hold", 1'b0, 1'b1, 4'hF);
        we = 1; wa = 4'd8; wd = 4'h1;
        cyc();
        we = 0;
        chk_used("used_saturated", 5'd16);
    endtask

    task automatic test_clear();
        int n;
        clr = 1; we = 1; wa = 4'd7; wd = 4'hF;
        cyc();
        clr = 0; we = 0;
        chk_used("used_on_clear", 5'd0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            n_vec++;
            if (rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL rvalid_during_busy: rvalid=%b at busy cycle %0d, required 0", rvalid, n);
            end
            re = 1; ra = 4'd7;
            cyc();
        end
        re = 0;
        n_vec++;
        if (n != 16) begin n_err++; $display("FAIL busy_length: busy cycles=%0d, required 16", n); end
        re = 1; ra = 4'd7;
        cyc();
        re = 0;
        chk_rd("read7_after_clear", 1'b1, 1'b0, 4'h0);
        chk_used("used_after_clear", 5'd0);
    endtask

    task automatic test_same_cycle();
        we = 1; wa = 4'd9; wd = 4'hC; re = 1; ra = 4'd9;
        cyc();
        we = 0; re = 0;
`ifdef RAM_SWEEP_FWD_EN
        chk_rd("same_addr_rw", 1'b1, 1'b1, 4'hC);
`else
        chk_rd("same_addr_rw", 1'b1, 1'b0, 4'h0);
`endif
        chk_used("used_same_addr", 5'd1);
        we = 1; wa = 4'd2; wd = 4'h5; re = 1; ra = 4'd9;
        cyc();
        we = 0; re = 0;
        chk_rd("diff_addr_rw", 1'b1, 1'b1, 4'hC);
        chk_used("used_diff_addr", 5'd2);
        re = 1; ra = 4'd2;
        cyc();
        re = 0;
        chk_rd("read2", 1'b1, 1'b1, 4'h5);
    endtask

    task automatic test_rst_mid_sweep();
        clr = 1;
        cyc();
        clr = 0;
        for (int i = 0; i < 8; i++) cyc();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy_mid_sweep: busy=%b, required 1", busy); end
        rst = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_async_rst: busy=%b, required 0", busy); end
        chk_used("used_async_rst", 5'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            re = 1; ra = 4'(i);
            cyc();
            chk_rd($sformatf("post_rst_read%0d", i), 1'b1, 1'b0, 4'h0);
        end
        re = 0;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_rst: busy=%b, required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_clear();
        test_same_cycle();
        test_rst_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
